// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) constant multiplies
// and the column-serial engine state encoding.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } imc_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] a);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(a)));
        return x8 ^ a;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] a);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(a);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ a;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] a);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(a));
        x8 = xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] a);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_col_seq_if.sv
// State-in / state-out valid-ready bundle for
// the column-serial InvMixColumns engine.
interface inv_mix_col_seq_if;

    logic [0:127] i_state;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] o_state;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output i_state,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  o_state,
        input  out_valid
    );

    modport slave (
        input  i_state,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output o_state,
        output out_valid
    );

endinterface

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column;
// byte a0 sits in the most significant byte.
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a [4];

    assign a[0] = col_in[31:24];
    assign a[1] = col_in[23:16];
    assign a[2] = col_in[15:8];
    assign a[3] = col_in[7:0];

    // out_r = 0e*a_r ^ 0b*a_r+1 ^ 0d*a_r+2 ^ 09*a_r+3
    always_comb begin
        col_out[31:24] = gf_mule(a[0]) ^ gf_mulb(a[1])
                       ^ gf_muld(a[2]) ^ gf_mul9(a[3]);
        col_out[23:16] = gf_mule(a[1]) ^ gf_mulb(a[2])
                       ^ gf_muld(a[3]) ^ gf_mul9(a[0]);
        col_out[15:8]  = gf_mule(a[2]) ^ gf_mulb(a[3])
                       ^ gf_muld(a[0]) ^ gf_mul9(a[1]);
        col_out[7:0]   = gf_mule(a[3]) ^ gf_mulb(a[0])
                       ^ gf_muld(a[1]) ^ gf_mul9(a[2]);
    end

endmodule

// File: rtl/inv_mix_col_seq.sv
// Column-serial InvMixColumns: one shared column
// datapath, four cycles per 128-bit state.
module inv_mix_col_seq
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    inv_mix_col_seq_if.slave bus
);

    imc_state_t   state_q;
    imc_state_t   state_d;
    logic [1:0]   col_q;
    logic [0:127] hold_q;
    logic [0:127] o_q;
    logic         in_ready;
    logic         out_valid;
    logic         accept;
    logic [6:0]   col_base;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    assign col_base = {col_q, 5'b0};
    assign col_in   = hold_q[col_base +: 32];
    assign accept   = bus.in_valid & in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.o_state   = o_q;

    inv_mix_column u_col (
        .col_in  (col_in),
        .col_out (col_out)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake decode
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    state_d = bus.in_valid ? BUSY : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture on accept, then write one column per BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= 2'd0;
            hold_q <= '0;
            o_q    <= '0;
        end else if (accept) begin
            col_q  <= 2'd0;
            hold_q <= bus.i_state;
        end else if (state_q == BUSY) begin
            o_q[col_base +: 32] <= col_out;
            if (col_q != 2'd3) begin
                col_q <= col_q + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_inv_mix_col_seq.sv
// Randomised bench for inv_mix_col_seq against a
// matrix-form GF(2^8) reference model.
module tb_inv_mix_col_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [127:0] din_q [$];
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    inv_mix_col_seq_if bus ();

    inv_mix_col_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Generic shift-and-add GF(2^8) multiply mod x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [8:0] t;
        p = 8'h00;
        t = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t[7:0];
            t = t << 1;
            if (t[8]) t = t ^ 9'h11b;
        end
        return p;
    endfunction

    // Circulant matrix product per column; inv selects the inverse matrix
    function automatic logic [127:0] mixm(input logic [127:0] v,
                                          input bit inv);
        logic [7:0]   m [4];
        logic [7:0]   s [16];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(m[k], s[4*c + (row+k)%4]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    // One block, optional junk in_valid pulses and DONE backpressure
    task automatic single(input string tag,
                          input logic [127:0] din,
                          input logic [127:0] exp,
                          input bit junk,
                          input int hold);
        int           lat;
        logic [127:0] snap;
        bus.i_state   = din;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        chk({tag, "_rdy"}, 128'(bus.in_ready), 128'd1);
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            if (junk) begin
                bus.in_valid = 1'($urandom % 2);
                bus.i_state  = rnd128();
            end
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 128'(lat), 128'd4);
        chk({tag, "_data"}, bus.o_state, exp);
        snap = bus.o_state;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom % 2);
            bus.i_state  = rnd128();
            tick();
            chk({tag, "_hold_v"}, 128'(bus.out_valid), 128'd1);
            chk({tag, "_hold_d"}, bus.o_state, snap);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_idle"}, 128'({bus.in_ready, bus.out_valid}), 128'd2);
    endtask

    // Stream din_q through, compare in order with exp_q
    task automatic stream(input string tag, input bit rnd_hs,
                          input bit chk_gap);
        int n;
        int sent;
        int got;
        int last;
        int cyc;
        bit hs_in;
        bit hs_out;
        n = din_q.size();
        sent = 0;
        got = 0;
        last = 0;
        cyc = 0;
        while (got < n && cyc < n*20 + 50) begin
            if (sent < n) begin
                bus.i_state  = din_q[sent];
                bus.in_valid = rnd_hs ? ($urandom % 4 != 0) : 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = rnd_hs ? ($urandom % 3 != 0) : 1'b1;
            #1;
            hs_in  = bus.in_valid && bus.in_ready;
            hs_out = bus.out_valid && bus.out_ready;
            if (hs_out) begin
                chk({tag, "_data"}, bus.o_state, exp_q[got]);
                if (chk_gap && got > 0)
                    chk({tag, "_gap"}, 128'(cyc - last), 128'd5);
                last = cyc;
                got++;
            end
            if (hs_in) sent++;
            tick();
            cyc++;
        end
        chk({tag, "_count"}, 128'(got), 128'(n));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
    endtask

    initial begin
        logic [127:0] x;
        bit           stale;
        rst_n         = 1'b0;
        bus.i_state   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        chk("rst_rdy", 128'(bus.in_ready), 128'd1);
        chk("rst_vld", 128'(bus.out_valid), 128'd0);
        chk("rst_data", bus.o_state, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();

        single("vec1", 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6,
               128'hdb135345_f20a225c_01010101_d4d4d4d5, 1'b1, 10);
        single("vec2", 128'hc6c6c6c6_4d7ebdf8_c6c6c6c6_4d7ebdf8,
               128'hc6c6c6c6_2d26314c_c6c6c6c6_2d26314c, 1'b0, 0);
        x = {16{8'h80}};
        single("all80", x, mixm(x, 1'b1), 1'b0, 0);
        x = {16{8'hff}};
        single("allff", x, mixm(x, 1'b1), 1'b0, 0);
        x = 128'h80ff0180_ff8001ff_1b80ff36_80808080;
        single("mixed", x, mixm(x, 1'b1), 1'b1, 3);

        bus.i_state  = rnd128();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("mid_vld", 128'(bus.out_valid), 128'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 128'(bus.out_valid), 128'd0);
        chk("arst_data", bus.o_state, 128'd0);
        chk("arst_rdy", 128'(bus.in_ready), 128'd1);
        tick();
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) stale = 1'b1;
        end
        chk("no_stale", 128'(stale), 128'd0);
        x = rnd128();
        single("post_rst", x, mixm(x, 1'b1), 1'b0, 0);

        din_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            x = rnd128();
            din_q.push_back(x);
            exp_q.push_back(mixm(x, 1'b1));
        end
        stream("b2b", 1'b0, 1'b1);

        din_q.delete();
        exp_q.delete();
        for (int i = 0; i < 1000; i++) begin
            x = rnd128();
            din_q.push_back(mixm(x, 1'b0));
            exp_q.push_back(x);
        end
        stream("rtrip", 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv_mix_col_seq.md
# inv_mix_col_seq

Column-serial AES-128 InvMixColumns engine for the decryption datapath. It accepts a 128-bit state from InvShiftRows/InvSubBytes through a valid/ready handshake. It transforms one 32-bit column per cycle over four cycles and presents the result under a valid/ready handshake. It is the decrypt-side counterpart of the single-cycle `mix_col`, and is area-reduced by sharing one column datapath.

## Interface
- No parameters. Block width is fixed at 128 bits and column count is fixed at 4.
- `clk` in 1 — rising-edge clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `i_state` in [0:127] — input state S(r,c). Byte S(r,c) occupies bits [32c+8r : 32c+8r+7]. Bit 0 is the MSB of S(0,0).
- `in_valid` in 1 — `i_state` is valid.
- `in_ready` out 1 — block can accept a state.
- `o_state` out [0:127] — InvMixColumns result. It uses the same byte mapping as `i_state`.
- `out_valid` out 1 — `o_state` holds a complete result.
- `out_ready` in 1 — consumer accepts `o_state`.

## Operation
- FSM states are IDLE, BUSY and DONE. A 2-bit column counter `col` is used in BUSY.
- IDLE:
  - `in_ready`=1 and `out_valid`=0.
  - When `in_valid` is high, capture `i_state` into an internal 128-bit holding register. Then `col`←0 and go to BUSY.
- BUSY:
  - `in_ready`=0 and `out_valid`=0. `in_valid` is ignored.
  - Each cycle, the holding-register column `col` is transformed and written into `o_state` column `col`, and `col` increments.
  - At `col`=3, go to DONE.
- DONE:
  - `out_valid`=1. `o_state` is held stable.
  - `in_ready` = `out_ready`.
  - If `out_ready` and `in_valid` are both high: capture the new state, set `col`←0, go to BUSY. This is a back-to-back accept.
  - If only `out_ready` is high: go to IDLE.
  - If `out_ready` is low: stay in DONE.
- Column transform. For column bytes a0..a3, out_r = 0e·a_r ⊕ 0b·a_(r+1) ⊕ 0d·a_(r+2) ⊕ 09·a_(r+3), with indices mod 4, in GF(2^8) mod 0x11B.
- GF multiplies use xtime, defined as xtime(a) = {a[1:7],0} ⊕ (a[0] ? 8'h1b : 0). With x2=xtime(a), x4=xtime(x2), x8=xtime(x4):
  - 09·a = x8⊕a
  - 0b·a = x8⊕x2⊕a
  - 0d·a = x8⊕x4⊕a
  - 0e·a = x8⊕x4⊕x2
- All arithmetic is 8-bit. There are no carries.
- Column counter wraps 3→0 only via a new accept, never on its own.

## Timing
- Reset values (asynchronous, with `rst_n` low):
  - state=IDLE, `col`=0.
  - `o_state`=128'h0, `out_valid`=0, holding register=0.
  - `in_ready`=1, because it is decoded from state.
- Latency: a handshake at edge T gives `out_valid`=1 after edge T+4. Columns 0..3 are written at edges T+1..T+4.
- Throughput: one block per 5 cycles with continuous `in_valid`/`out_ready`.
- `o_state` columns are visibly partial during BUSY. Consumers must qualify with `out_valid`.
- `in_ready` and `out_valid` are combinational from state and `out_ready`. There is no combinational path from `in_valid` to `in_ready`.
- Reset asserted mid-BUSY or in DONE discards the block immediately. After `rst_n` deasserts, the first edge can accept new data.
- In DONE, holding `out_ready` low any number of cycles keeps `o_state` and `out_valid` unchanged.

## Structure
- Shared package `aes_pkg`:
  - `xtime` function
  - `gf_mul9`/`gf_mulb`/`gf_muld`/`gf_mule` functions
  - FSM state enum (IDLE/BUSY/DONE)
  - constant `AES_POLY`=8'h1b
- Sub-module `inv_mix_column`: purely combinational 32-bit column transform. It is instantiated once and muxed by `col`. The same module is reusable for an unrolled variant.
- Top holds the FSM, counter, holding register and output register.

## Test plan
- Reset: assert `rst_n`=0 mid-BUSY → `out_valid`=0 and `o_state`=0 immediately. After release, `in_ready`=1 and no stale output appears.
- Single block: input columns 8e4da1bc 9fdc589d 01010101 d5d5d7d6 → `o_state` = db135345 f20a225c 01010101 d4d4d4d5. `out_valid` rises exactly 4 edges after accept.
- Round trip: random 128-bit X → `mix_col` → this block returns X, over 1000 vectors. Include columns c6c6c6c6 (self-inverse) and 4d7ebdf8 → 2d26314c.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `o_state`/`out_valid` stable. Pulsing `in_valid` during BUSY/DONE without a handshake is ignored.
- Back-to-back: `in_valid` and `out_ready` held high for 4 blocks → one result every 5 cycles, in order, with no dropped or duplicated block.
- xtime boundary: input all 8'h80 and all 8'hff → match a golden model. This exercises the reduction on every multiply stage.
